apb3_multi_master: RTL
======================

Name: apb3_multi_master

Overview:
- Parametrised APB3 master bridging a valid/ready request port from the top module onto an APB3 bus with NUM_SLAVES selects.
- Proper IDLE/SETUP/ACCESS FSM replaces change-detect triggering.
- Adds explicit handshakes, PSLVERR propagation, address-decode error and a registered response port.
- Sits between the system controller and the APB slave memories/peripherals.

Parameters:
- ADDR_WIDTH, 8, APB address width; valid range 2..32.
- DATA_WIDTH, 32, APB data width; valid range 1..32.
- NUM_SLAVES, 4, number of psel outputs; valid range 2..16.
- TIMEOUT_CYCLES, 16, ACCESS wait limit; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- preset  in  1  asynchronous, active-high reset
- req_valid  in  1  top request valid
- req_ready  out  1  master can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  slave error, decode error or timeout
- paddr  out  ADDR_WIDTH  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- psel  out  NUM_SLAVES  one-hot slave select
- penable  out  1  APB enable
- prdata  in  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset state:
  - FSM=IDLE; req_ready=1.
  - paddr, pwdata, pwrite, psel, penable, rsp_valid, rsp_rdata, rsp_err all 0.
- Decode:
  - SEL_BITS = max(1, clog2(NUM_SLAVES)).
  - Slave index = req_addr[ADDR_WIDTH-1 -: SEL_BITS].
  - An index >= NUM_SLAVES is a decode error.
- Handshake:
  - Request accepted when req_valid & req_ready.
  - req_ready=1 only in IDLE.
  - req_* is sampled into paddr/pwrite/pwdata/sel registers at accept.
  - The bus outputs stay stable until the transfer ends.
  - pwdata is captured for reads too; slaves ignore it.
- FSM:
  - IDLE: on accept with a valid index, go to SETUP. On accept with a decode error, go to RESP.
  - SETUP: psel[idx]=1, penable=0; lasts exactly 1 cycle, then ACCESS.
  - ACCESS: psel[idx]=1, penable=1. Wait while pready[idx]=0. When pready[idx]=1, capture prdata slice and pslverr[idx], then go to RESP.
  - RESP: psel=0, penable=0; rsp_valid=1 for 1 cycle, then IDLE.
- Response data and error:
  - Decode-error response: rsp_err=1, rsp_rdata=0, no psel asserted.
  - rsp_rdata = captured data only for a read with pslverr=0; otherwise 0.
  - rsp_err = captured pslverr (or decode/timeout error).
- Latency:
  - Zero-wait transfer: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - Each wait state adds 1 cycle.
  - Next accept is possible in the cycle after rsp_valid, giving a minimum of 4 cycles per transfer.
  - Decode error: rsp_valid in the cycle after accept.
- Bus ignore rules:
  - pready/pslverr of non-selected slaves are ignored.
  - pready is ignored in SETUP and IDLE.
- No pipelining: req_valid held while req_ready=0 has no effect.
- Reset mid-transfer: asynchronous return to IDLE with all outputs at reset values. No response is produced for the aborted transfer.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready[idx]=0.
  - On reaching TIMEOUT_CYCLES the FSM goes to RESP with rsp_err=1, rsp_rdata=0.
  - psel/penable drop in RESP, aborting the transfer.
  - pready arriving in the same cycle the count is reached wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb3_pkg contains:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - a sel_bits(NUM_SLAVES) constant function;
  - response error-cause localparams (ERR_NONE, ERR_SLV, ERR_DEC, ERR_TMO), used internally and visible to the bench.
- Sub-module apb3_addr_decoder (combinational):
  - inputs: addr;
  - outputs: one-hot sel, index, dec_err;
  - instantiated once on req_addr.

Test Plan:
- Write with zero wait states:
  - Stimulus: req_addr=0x45, wdata=0xDEADBEEF, slave 1 pready=1.
  - Response: psel=4'b0010 in cycles 1-2; penable only in cycle 2; rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: req_addr=0xC0; slave 3 pready low for 3 ACCESS cycles; prdata slice=0x12345678.
  - Response: rsp_valid at cycle 6, rsp_rdata=0x12345678, paddr stable throughout.
- Slave error:
  - Stimulus: read from 0x10 with pslverr[0]=1 at the pready cycle.
  - Response: rsp_err=1, rsp_rdata=0.
- Decode error:
  - Stimulus: NUM_SLAVES=3, req_addr=0xC0.
  - Response: psel stays 0; rsp_valid=1, rsp_err=1 one cycle after accept.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: pready held 0.
  - Response: rsp_err=1 after 4 ACCESS cycles; psel/penable=0 in RESP.
  - Repeat with pready=1 on the 4th ACCESS cycle: normal completion.
- Reset mid-ACCESS:
  - Stimulus: assert preset while penable=1.
  - Response: psel/penable/rsp_valid drop immediately, req_ready=1. A new request afterwards completes normally.

Source files
------------

// File: rtl/apb3_pkg.sv
// Shared definitions for the APB3 multi-master bridge: FSM states, select-width
// helper and response error-cause codes.
package apb3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SLV  = 2'd1;
  localparam logic [1:0] ERR_DEC  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  function automatic int sel_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb3_addr_decoder.sv
// Combinational slave decoder: top address bits pick the slave, and indices
// beyond NUM_SLAVES flag a decode error.
module apb3_addr_decoder
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = sel_bits(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [SEL_BITS-1:0]   index,
  output logic                  dec_err
);

  assign index = addr[ADDR_WIDTH-1 -: SEL_BITS];

  // Only a non-power-of-two slave count leaves unused index codes.
  if ((1 << SEL_BITS) > NUM_SLAVES) begin : g_dec_err
    assign dec_err = (index >= SEL_BITS'(NUM_SLAVES));
  end else begin : g_no_dec_err
    assign dec_err = 1'b0;
  end

  assign sel = dec_err ? '0 : (NUM_SLAVES'(1) << index);

endmodule

// File: rtl/apb3_multi_master.sv
// APB3 master with valid/ready request port, IDLE/SETUP/ACCESS/RESP FSM and
// registered response. Optional ACCESS timeout is enabled by APB_TIMEOUT_EN.
module apb3_multi_master
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int SEL_BITS = sel_bits(NUM_SLAVES);

  apb_state_t              r_state;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [NUM_SLAVES-1:0]   r_sel;
  logic [SEL_BITS-1:0]     r_idx;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_err_cause;

  logic [NUM_SLAVES-1:0]   w_sel;
  logic [SEL_BITS-1:0]     w_idx;
  logic                    w_dec_err;
  logic                    w_pready;
  logic                    w_pslverr;
  logic [DATA_WIDTH-1:0]   w_rdata;

  apb3_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_dec (
    .addr    (req_addr),
    .sel     (w_sel),
    .index   (w_idx),
    .dec_err (w_dec_err)
  );

  // Only the selected slave's handshake and data are observed.
  assign w_pready  = |(pready & r_sel);
  assign w_pslverr = |(pslverr & r_sel);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SEL_BITS'(i) == r_idx) w_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_sel       <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err_cause <= ERR_NONE;
`ifdef APB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_sel    <= w_sel;
            r_idx    <= w_idx;
            if (w_dec_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_err_cause <= ERR_DEC;
            end else begin
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          r_state <= ACCESS;
`ifdef APB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        ACCESS: begin
          // A ready in the final allowed cycle still completes normally.
          if (w_pready) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (!r_pwrite && !w_pslverr) ? w_rdata : '0;
            r_err_cause <= w_pslverr ? ERR_SLV : ERR_NONE;
          end
`ifdef APB_TIMEOUT_EN
          else if (w_timeout) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_err_cause <= ERR_TMO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= '0;
          r_err_cause <= ERR_NONE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign psel      = ((r_state == SETUP) || (r_state == ACCESS)) ? r_sel : '0;
  assign penable   = (r_state == ACCESS);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = (r_err_cause != ERR_NONE);

endmodule
